// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared types and the channel-index width helper for timer_bank
package timer_bank_pkg;
  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} mode_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one programmable periodic/one-shot counter advanced by the shared strobe
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe,
  input  logic             wr,
  input  logic             wr_start,
  input  logic [WIDTH-1:0] wr_period,
  input  logic             wr_mode,
  input  logic             stop,
  output logic             tick,
  output logic             running
);
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  mode_t            mode;
  state_t           state;
  logic             expire;
  // one extra bit keeps count+1 from wrapping at the largest period
  assign expire = ({1'b0, count} + (WIDTH+1)'(1)) >= {1'b0, period};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      period  <= '0;
      count   <= '0;
      mode    <= MODE_PERIODIC;
      state   <= ST_IDLE;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr) begin
        period <= wr_period;
        mode   <= mode_t'(wr_mode);
      end
      if (stop) begin
        state   <= ST_IDLE;
        count   <= '0;
        running <= 1'b0;
      end else if (wr && wr_start) begin
        state   <= |wr_period ? ST_RUN : ST_IDLE;
        running <= |wr_period;
        count   <= '0;
      end else if (!wr && state == ST_RUN && strobe) begin
        if (expire) begin
          tick  <= 1'b1;
          count <= '0;
          if (mode == MODE_ONESHOT) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
endmodule

// File: rtl/timer_bank.sv
// timer_bank: shared prescaler feeding CHANNELS independent tick generators
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PRESCALE_WIDTH-1:0]    prescale,
  input  logic                         wr_en,
  input  logic [chan_w(CHANNELS)-1:0]  wr_chan,
  input  logic [WIDTH-1:0]             wr_period,
  input  logic                         wr_mode,
  input  logic                         wr_start,
  input  logic [CHANNELS-1:0]          stop,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          running
);
  localparam int CW = chan_w(CHANNELS);
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic                      strobe;
  // >= rather than == so a shrinking prescale never waits for a wrap
  assign strobe = pcnt >= prescale;
  always_ff @(posedge clock or negedge reset)
    if (!reset) pcnt <= '0;
    else pcnt <= strobe ? '0 : pcnt + PRESCALE_WIDTH'(1);
  genvar i;
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clock    (clock),
      .reset    (reset),
      .strobe   (strobe),
      .wr       (wr_en && wr_chan == CW'(i)),
      .wr_start (wr_start),
      .wr_period(wr_period),
      .wr_mode  (wr_mode),
      .stop     (stop[i]),
      .tick     (tick[i]),
      .running  (running[i])
    );
  end
endmodule
